// File: rtl/ch77_restart_poller.sv
// Channel 77 restart-monitor poller: periodically reads the nine AGC alarm bits over the monitor bus.
// Optional CH77_AUTOCLEAR_EN adds a write-clear (MWCH) phase after any nonzero read.
module ch77_restart_poller #(
  parameter int POLL_DIV = 1024,
  parameter int PULSE_W  = 4
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       poll_en,
  input  logic       poll_now,
  input  logic       sticky_clr,
  input  logic       MDT01,
  input  logic       MDT02,
  input  logic       MDT03,
  input  logic       MDT04,
  input  logic       MDT05,
  input  logic       MDT06,
  input  logic       MDT07,
  input  logic       MDT08,
  input  logic       MDT09,
  output logic       MWL01,
  output logic       MWL02,
  output logic       MWL03,
  output logic       MWL04,
  output logic       MWL05,
  output logic       MWL06,
  output logic       MWSG,
  output logic       MT01,
  output logic       MRCH,
  output logic       MWCH,
  output logic       MT12,
  output logic       busy,
  output logic [8:0] alarm_word,
  output logic       alarm_valid,
  output logic [8:0] alarm_sticky
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEL,
    S_RD,
`ifdef CH77_AUTOCLEAR_EN
    S_CLR,
`endif
    S_END
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(POLL_DIV - 1);
  localparam logic [3:0]  PH_LAST  = 4'(PULSE_W - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_phase;
  logic        r_addr;
  logic        r_mt01;
  logic        r_mrch;
  logic        r_mt12;
  logic        r_busy;
  logic [8:0]  r_word;
  logic        r_valid;
  logic [8:0]  r_sticky;
  logic [8:0]  w_mdt;
  logic        w_phase_done;
  logic        w_capture;

  assign w_mdt        = {MDT09, MDT08, MDT07, MDT06, MDT05, MDT04, MDT03, MDT02, MDT01};
  assign w_phase_done = (r_phase == 4'd0);
  assign w_capture    = (r_state == S_RD) && w_phase_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if ((poll_en && r_cnt == DIV_LAST) || poll_now) w_next = S_SETUP;
      S_SETUP: w_next = S_SEL;
      S_SEL:   if (w_phase_done) w_next = S_RD;
`ifdef CH77_AUTOCLEAR_EN
      S_RD:    if (w_phase_done) w_next = (w_mdt != 9'd0) ? S_CLR : S_END;
      S_CLR:   if (w_phase_done) w_next = S_END;
`else
      S_RD:    if (w_phase_done) w_next = S_END;
`endif
      S_END:   if (w_phase_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_phase  <= 4'd0;
      r_addr   <= 1'b0;
      r_mt01   <= 1'b0;
      r_mrch   <= 1'b0;
      r_mt12   <= 1'b0;
      r_busy   <= 1'b0;
      r_word   <= 9'd0;
      r_valid  <= 1'b0;
      r_sticky <= 9'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_IDLE && w_next == S_IDLE) ? r_cnt + 16'd1 : 16'd0;
      if (w_next != r_state)
        r_phase <= PH_LAST;
      else if (!w_phase_done)
        r_phase <= r_phase - 4'd1;
`ifdef CH77_AUTOCLEAR_EN
      r_addr  <= (w_next == S_SETUP) || (w_next == S_SEL) || (w_next == S_RD) || (w_next == S_CLR);
`else
      r_addr  <= (w_next == S_SETUP) || (w_next == S_SEL) || (w_next == S_RD);
`endif
      r_mt01  <= (w_next == S_SEL);
      r_mrch  <= (w_next == S_RD);
      r_mt12  <= (w_next == S_END);
      r_busy  <= (w_next != S_IDLE);
      r_valid <= w_capture;
      if (w_capture) begin
        r_word   <= w_mdt;
        r_sticky <= sticky_clr ? w_mdt : (r_sticky | w_mdt);
      end else if (sticky_clr) begin
        r_sticky <= 9'd0;
      end
    end
  end

`ifdef CH77_AUTOCLEAR_EN
  logic r_mwch;
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) r_mwch <= 1'b0;
    else         r_mwch <= (w_next == S_CLR);
  end
  assign MWCH = r_mwch;
`else
  assign MWCH = 1'b0;
`endif

  assign {MWL06, MWL05, MWL04, MWL03, MWL02, MWL01} = {6{r_addr}};
  assign MWSG         = r_addr;
  assign MT01         = r_mt01;
  assign MRCH         = r_mrch;
  assign MT12         = r_mt12;
  assign busy         = r_busy;
  assign alarm_word   = r_word;
  assign alarm_valid  = r_valid;
  assign alarm_sticky = r_sticky;

endmodule

// File: tb/tb_ch77_restart_poller.sv
// Bench for ch77_restart_poller: poll-offset model checked every cycle, plus directed literal checks.
module tb_ch77_restart_poller;
  localparam int PD = 16;
  localparam int PW = 2;
`ifdef CH77_AUTOCLEAR_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_en = 1'b0;
  logic       poll_now = 1'b0;
  logic       sticky_clr = 1'b0;
  logic [8:0] mdt = 9'd0;
  logic       MWL01, MWL02, MWL03, MWL04, MWL05, MWL06;
  logic       MWSG, MT01, MRCH, MWCH, MT12, busy, alarm_valid;
  logic [8:0] alarm_word, alarm_sticky;

  int checks = 0;
  int failures = 0;

  ch77_restart_poller #(.POLL_DIV(PD), .PULSE_W(PW)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .poll_en(poll_en), .poll_now(poll_now),
    .sticky_clr(sticky_clr),
    .MDT01(mdt[0]), .MDT02(mdt[1]), .MDT03(mdt[2]), .MDT04(mdt[3]), .MDT05(mdt[4]),
    .MDT06(mdt[5]), .MDT07(mdt[6]), .MDT08(mdt[7]), .MDT09(mdt[8]),
    .MWL01(MWL01), .MWL02(MWL02), .MWL03(MWL03), .MWL04(MWL04), .MWL05(MWL05), .MWL06(MWL06),
    .MWSG(MWSG), .MT01(MT01), .MRCH(MRCH), .MWCH(MWCH), .MT12(MT12), .busy(busy),
    .alarm_word(alarm_word), .alarm_valid(alarm_valid), .alarm_sticky(alarm_sticky)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endfunction

  // Model: a poll is a run of offsets from its SETUP cycle; outputs follow from the offset.
  bit       m_busy = 1'b0;
  bit       m_clr = 1'b0;
  bit       m_valid = 1'b0;
  int       m_off = 0;
  int       m_cnt = 0;
  logic [8:0] m_word = 9'd0;
  logic [8:0] m_sticky = 9'd0;

  always @(negedge clk) begin
    int  len;
    bit  e_addr, e_mt01, e_mrch, e_mwch, e_mt12;
    e_addr = 1'b0; e_mt01 = 1'b0; e_mrch = 1'b0; e_mwch = 1'b0; e_mt12 = 1'b0;
    if (!rst && m_busy) begin
      e_addr = (m_off <= 2*PW) || (m_clr && m_off <= 3*PW);
      e_mt01 = (m_off >= 1) && (m_off <= PW);
      e_mrch = (m_off >= PW+1) && (m_off <= 2*PW);
      e_mwch = m_clr && (m_off >= 2*PW+1) && (m_off <= 3*PW);
      e_mt12 = (m_off >= (m_clr ? 3*PW+1 : 2*PW+1));
    end
    chk("mwl", int'({MWL06, MWL05, MWL04, MWL03, MWL02, MWL01}), e_addr ? 'h3f : 0);
    chk("mwsg", int'(MWSG), int'(e_addr));
    chk("mt01", int'(MT01), int'(e_mt01));
    chk("mrch", int'(MRCH), int'(e_mrch));
    chk("mwch", int'(MWCH), int'(e_mwch));
    chk("mt12", int'(MT12), int'(e_mt12));
    chk("busy", int'(busy), rst ? 0 : int'(m_busy));
    chk("alarm_word", int'(alarm_word), rst ? 0 : int'(m_word));
    chk("alarm_valid", int'(alarm_valid), rst ? 0 : int'(m_valid));
    chk("alarm_sticky", int'(alarm_sticky), rst ? 0 : int'(m_sticky));
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_word = 9'd0; m_sticky = 9'd0; m_valid = 1'b0; m_clr = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (!m_busy) begin
        if (sticky_clr) m_sticky = 9'd0;
        if ((poll_en && m_cnt == PD-1) || poll_now) begin
          m_busy = 1'b1; m_off = 0; m_clr = 1'b0;
        end else begin
          m_cnt = (m_cnt + 1) % 65536;
        end
      end else begin
        if (m_off == 2*PW) begin
          m_word   = mdt;
          m_sticky = sticky_clr ? mdt : (m_sticky | mdt);
          m_valid  = 1'b1;
          m_clr    = AC && (mdt != 9'd0);
        end else if (sticky_clr) begin
          m_sticky = 9'd0;
        end
        len = m_clr ? 1 + 4*PW : 1 + 3*PW;
        if (m_off == len - 1) begin
          m_busy = 1'b0; m_cnt = 0;
        end else begin
          m_off++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin tick(1); k++; end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic cycles_to_setup(output int k);
    k = 0;
    while (!MWSG && k < 200) begin tick(1); k++; end
  endtask

  task automatic do_poll(input logic [8:0] v);
    mdt = v;
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    wait_idle();
  endtask

  initial begin
    int k;
    int len;
    // Reset state and quiet idle with polling disabled.
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_word", int'(alarm_word), 0);
    chk("rst_sticky", int'(alarm_sticky), 0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 5000; i++) begin tick(1); if (MT01) k++; end
    chk("no_poll_mt01_count", k, 0);
    chk("no_poll_busy", int'(busy), 0);

    // Periodic poll timing from reset release.
    rst = 1'b1; poll_en = 1'b1; tick(2); rst = 1'b0;
    cycles_to_setup(k);
    chk("first_setup_cycle", k, 16);
    len = 0;
    while (busy && len < 100) begin tick(1); len++; end
    chk("poll_len_zero", len, 7);
    cycles_to_setup(k);
    chk("next_setup_cycle", k, 16);
    poll_en = 1'b0;
    wait_idle();

    // Alarm capture via poll_now.
    mdt = 9'h021;
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    chk("poll_now_setup", int'(MWSG), 1);
    len = 0;
    while (busy && len < 100) begin tick(1); len++; end
    chk("poll_len_alarm", len, AC ? 9 : 7);
    chk("word_021", int'(alarm_word), 'h021);
    chk("sticky_021", int'(alarm_sticky), 'h021);

    // Sticky accumulation and clear-on-capture.
    sticky_clr = 1'b1; tick(1); sticky_clr = 1'b0;
    chk("sticky_cleared", int'(alarm_sticky), 0);
    do_poll(9'h004);
    do_poll(9'h100);
    chk("sticky_104", int'(alarm_sticky), 'h104);
    mdt = 9'h001;
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    tick(2*PW);
    sticky_clr = 1'b1; tick(1); sticky_clr = 1'b0;
    chk("sticky_clr_capture", int'(alarm_sticky), 'h001);
    chk("valid_after_capture", int'(alarm_valid), 1);
    wait_idle();

    // poll_now while busy is ignored.
    mdt = 9'h000;
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    tick(PW+1);
    chk("in_rd", int'(MRCH), 1);
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    wait_idle();
    k = 0;
    for (int i = 0; i < 30; i++) begin tick(1); if (busy) k++; end
    chk("no_queued_poll", k, 0);

    // poll_now restarts the divider.
    poll_en = 1'b1; tick(5);
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    wait_idle();
    cycles_to_setup(k);
    chk("div_restart", k, 16);
    poll_en = 1'b0;
    wait_idle();

    // Asynchronous reset mid-RD.
    mdt = 9'h0ff;
    poll_now = 1'b1; tick(1); poll_now = 1'b0;
    tick(PW+1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mrch", int'(MRCH), 0);
    chk("arst_mwsg", int'(MWSG), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sticky", int'(alarm_sticky), 0);
    tick(1); rst = 1'b0;
    tick(20);
    chk("arst_lost_valid", int'(alarm_valid), 0);
    chk("arst_word", int'(alarm_word), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ch77_restart_poller.md
# ch77_restart_poller

Monitor-side initiator for the channel 77 restart-monitor (alarm) register. It periodically addresses channel 77 over the monitor interface and reads back the nine alarm bits on MDT01–MDT09. When configured to, it issues a write-clear strobe after any nonzero read. The block sits in the test-set/monitor logic, across the interface from the AGC's alarm latches. It presents the captured alarm word and a sticky accumulation to host logic.

## Interface
Parameters:
- POLL_DIV, 1024: IDLE cycles between polls; legal range 2..65535.
- PULSE_W, 4: width in cycles of each MT01/MRCH/MWCH/MT12 phase; legal range 1..16.

Ports:
- SIM_CLK  input  1  sole clock; all state changes on rising edge.
- SIM_RST  input  1  asynchronous, active-high reset.
- poll_en  input  1  enables periodic polling.
- poll_now  input  1  single-cycle request for an immediate poll; honoured only in IDLE.
- sticky_clr  input  1  clears alarm_sticky.
- MDT01..MDT09  input  1 each  monitor data lines; MDT01 is alarm_word[0].
- MWL01..MWL06  output  1 each  channel address; all 1 means channel 77.
- MWSG  output  1  write-select/address-valid qualifier.
- MT01  output  1  address-latch timing pulse.
- MRCH  output  1  read-channel strobe.
- MWCH  output  1  write-channel (clear) strobe.
- MT12  output  1  end-of-cycle pulse; releases the address latch.
- busy  output  1  high in every state except IDLE.
- alarm_word  output  9  last captured MDT09..MDT01.
- alarm_valid  output  1  one-cycle pulse; alarm_word was just updated.
- alarm_sticky  output  9  OR of all captures since the last clear.

Alarm bit map, bit0..bit8: parity fail (any), erasable parity fail, TC trap, RUPT lock, night watchman, voltage fail, counter fail, scaler fail, scaler double.

## Operation
- States are IDLE, SETUP, SEL, RD, CLR, END.
- IDLE
  - All bus outputs are 0.
  - The divider counter increments every cycle.
  - Go to SETUP when (poll_en and cnt==POLL_DIV-1) or poll_now.
  - cnt returns to 0 on every exit from IDLE.
- SETUP, 1 cycle: MWL01..06=1, MWSG=1.
- SEL, PULSE_W cycles: MT01=1. MWL and MWSG stay held.
- RD, PULSE_W cycles
  - MRCH=1. MWL and MWSG stay held.
  - MDT01..09 are sampled on the final RD cycle into alarm_word.
  - The same sample is ORed into alarm_sticky.
- Exit from RD: go to CLR if CH77_AUTOCLEAR_EN is defined and the sampled word is nonzero. Otherwise go to END.
- CLR, PULSE_W cycles: MWCH=1. MWL and MWSG stay held.
- END, PULSE_W cycles: MT12=1, MWL=0, MWSG=0. Then go to IDLE.
- Strobes never overlap; exactly one of MT01/MRCH/MWCH/MT12 is high in each non-SETUP/IDLE cycle.
- Deasserting poll_en mid-poll does not abort; the poll completes.
- poll_now while busy is ignored, not queued.
- alarm_sticky
  - sticky_clr alone clears it to 0.
  - sticky_clr coinciding with a capture gives alarm_sticky = the new word only.
  - A capture of 0 leaves it unchanged.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, cnt 0.
  - All bus outputs 0, busy 0.
  - alarm_word 0, alarm_sticky 0, alarm_valid 0.
- Reset mid-poll: strobes drop at once; no alarm_valid is produced; the interrupted poll is lost.
- Periodic poll start: the SETUP cycle begins POLL_DIV cycles after IDLE entry (or after reset release).
- poll_now: a request in IDLE cycle t gives SETUP in cycle t+1.
- Capture timing: MDT is sampled on the rising edge that ends the last RD cycle. alarm_word, alarm_sticky and alarm_valid update on that same edge. alarm_valid is high for exactly the first CLR or END cycle.
- Poll length: 1 + 3·PULSE_W cycles without clear, 1 + 4·PULSE_W cycles with clear.
- The PULSE_W phase counter is 4 bits and reloads at each phase entry. The divider is 16 bits and wraps only via the IDLE exit.

## Configuration
- CH77_AUTOCLEAR_EN defined: CLR phase is present; every nonzero capture is followed by a PULSE_W-cycle MWCH pulse before MT12.
- CH77_AUTOCLEAR_EN undefined: the CLR state is not compiled; MWCH is tied to 0; alarms remain latched on the far side.

## Test plan
- Reset: assert SIM_RST mid-RD → all outputs 0 in the same cycle. Release with poll_en=0 → no MT01 for 5000 cycles; busy=0.
- Idle poll: POLL_DIV=16, PULSE_W=2, poll_en=1, MDT=0 → expected sequence and response:
  - SETUP at cycle 16, then MT01 2 cycles, MRCH 2 cycles, MT12 2 cycles.
  - MWCH never high; alarm_word=0; one alarm_valid pulse.
  - Next SETUP 16 cycles after END.
- Alarm capture with CH77_AUTOCLEAR_EN: MDT = 9'h021 during RD → alarm_word=0x021 and alarm_sticky=0x021. MWCH is high for 2 cycles between MRCH and MT12. Repeat without the macro → MWCH stays 0 and the poll is 7 cycles.
- Sticky: capture 0x004, then 0x100 → alarm_sticky=0x104. Assert sticky_clr on the capture edge of a 0x001 read → alarm_sticky=0x001.
- poll_now: pulse in IDLE at cycle t → SETUP at t+1, cnt reset to 0. Pulse during RD → no extra poll follows.
- Address drive: during SETUP/SEL/RD/CLR, MWL01..06=1 and MWSG=1. During END and IDLE, all 0.
